// File: rtl/absorb_squeeze_fsm.sv
// Absorb/permute/squeeze sequencer for the Keccak-f datapath of the SHAKE core.
// Optional build macro SHAKE_ROUND_UNROLL2_EN: two rounds per round_en, rc steps by 2.
module absorb_squeeze_fsm #(
  parameter int NUM_ROUNDS = 24,
  parameter int ROUND_W    = $clog2(NUM_ROUNDS),
  parameter int OUT_LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 control_regs_valid,
  input  logic [OUT_LEN_W-1:0] out_len_blocks,
  input  logic                 input_buffer_ready_rd,
  input  logic                 last_block_in_buffer_rd,
  output logic                 input_buffer_consumed,
  input  logic                 output_buffer_empty,
  output logic                 state_reset,
  output logic                 state_absorb_en,
  output logic                 round_en,
  output logic [ROUND_W-1:0]   round_idx,
  output logic                 output_buffer_load,
  output logic                 output_buffer_last,
  output logic                 busy
);

`ifdef SHAKE_ROUND_UNROLL2_EN
  localparam int RC_STEP_I = 2;
  localparam int RC_LAST_I = NUM_ROUNDS - 2;
  if (NUM_ROUNDS % 2 != 0) begin : g_even_check
    $error("NUM_ROUNDS must be even when two rounds are applied per round_en");
  end
`else
  localparam int RC_STEP_I = 1;
  localparam int RC_LAST_I = NUM_ROUNDS - 1;
`endif

  localparam logic [ROUND_W-1:0] RC_STEP = ROUND_W'(RC_STEP_I);
  localparam logic [ROUND_W-1:0] RC_LAST = ROUND_W'(RC_LAST_I);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_BLOCK   = 2'd1,
    PERMUTE      = 2'd2,
    SQUEEZE_WAIT = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [ROUND_W-1:0]     rc, rc_next;
  logic [OUT_LEN_W-1:0]   rem, rem_next;
  logic                   last_seen, last_seen_next;
  logic                   squeezing, squeezing_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rc        <= '0;
      rem       <= '0;
      last_seen <= 1'b0;
      squeezing <= 1'b0;
    end else begin
      state     <= state_next;
      rc        <= rc_next;
      rem       <= rem_next;
      last_seen <= last_seen_next;
      squeezing <= squeezing_next;
    end
  end

  // Outputs are forced low while rst is high so no pulse escapes in the reset cycle.
  always_comb begin
    state_next            = state;
    rc_next               = rc;
    rem_next              = rem;
    last_seen_next        = last_seen;
    squeezing_next        = squeezing;
    input_buffer_consumed = 1'b0;
    state_reset           = 1'b0;
    state_absorb_en       = 1'b0;
    round_en              = 1'b0;
    round_idx             = '0;
    output_buffer_load    = 1'b0;
    output_buffer_last    = 1'b0;
    busy                  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (control_regs_valid) begin
            state_reset    = 1'b1;
            rem_next       = (out_len_blocks == '0) ? OUT_LEN_W'(1) : out_len_blocks;
            last_seen_next = 1'b0;
            squeezing_next = 1'b0;
            state_next     = WAIT_BLOCK;
          end
        end
        WAIT_BLOCK: begin
          busy = 1'b1;
          if (input_buffer_ready_rd) begin
            state_absorb_en       = 1'b1;
            input_buffer_consumed = 1'b1;
            last_seen_next        = last_block_in_buffer_rd;
            rc_next               = '0;
            state_next            = PERMUTE;
          end
        end
        PERMUTE: begin
          busy      = 1'b1;
          round_en  = 1'b1;
          round_idx = rc;
          if (rc == RC_LAST) begin
            if (squeezing) begin
              state_next = SQUEEZE_WAIT;
            end else if (last_seen) begin
              squeezing_next = 1'b1;
              state_next     = SQUEEZE_WAIT;
            end else begin
              state_next = WAIT_BLOCK;
            end
          end else begin
            rc_next = rc + RC_STEP;
          end
        end
        SQUEEZE_WAIT: begin
          busy = 1'b1;
          if (output_buffer_empty) begin
            output_buffer_load = 1'b1;
            output_buffer_last = (rem == OUT_LEN_W'(1));
            if (rem == OUT_LEN_W'(1)) begin
              state_next = IDLE;
            end else begin
              rem_next   = rem - OUT_LEN_W'(1);
              rc_next    = '0;
              state_next = PERMUTE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_squeeze_fsm.sv
// Directed bench for absorb_squeeze_fsm; honours SHAKE_ROUND_UNROLL2_EN when defined.
module tb_absorb_squeeze_fsm;
  localparam int NR        = 24;
  localparam int ROUND_W   = $clog2(NR);
  localparam int OUT_LEN_W = 16;
`ifdef SHAKE_ROUND_UNROLL2_EN
  localparam int RSTEP = 2;
`else
  localparam int RSTEP = 1;
`endif
  localparam int RCYC = NR / RSTEP;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 control_regs_valid;
  logic [OUT_LEN_W-1:0] out_len_blocks;
  logic                 input_buffer_ready_rd;
  logic                 last_block_in_buffer_rd;
  logic                 input_buffer_consumed;
  logic                 output_buffer_empty;
  logic                 state_reset;
  logic                 state_absorb_en;
  logic                 round_en;
  logic [ROUND_W-1:0]   round_idx;
  logic                 output_buffer_load;
  logic                 output_buffer_last;
  logic                 busy;

  int vectors = 0;
  int miscompares = 0;

  absorb_squeeze_fsm #(.NUM_ROUNDS(NR), .ROUND_W(ROUND_W), .OUT_LEN_W(OUT_LEN_W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .control_regs_valid     (control_regs_valid),
    .out_len_blocks         (out_len_blocks),
    .input_buffer_ready_rd  (input_buffer_ready_rd),
    .last_block_in_buffer_rd(last_block_in_buffer_rd),
    .input_buffer_consumed  (input_buffer_consumed),
    .output_buffer_empty    (output_buffer_empty),
    .state_reset            (state_reset),
    .state_absorb_en        (state_absorb_en),
    .round_en               (round_en),
    .round_idx              (round_idx),
    .output_buffer_load     (output_buffer_load),
    .output_buffer_last     (output_buffer_last),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; sample at the falling edge, then advance one cycle.
  task automatic outs(input string tag, input int cons, input int absb, input int sres,
                      input int ren, input int ridx, input int load, input int last,
                      input int bsy);
    @(negedge clk);
    chk({tag, ".consumed"}, int'(input_buffer_consumed), cons);
    chk({tag, ".absorb"},   int'(state_absorb_en),       absb);
    chk({tag, ".sreset"},   int'(state_reset),           sres);
    chk({tag, ".round_en"}, int'(round_en),              ren);
    chk({tag, ".ridx"},     int'(round_idx),             ridx);
    chk({tag, ".load"},     int'(output_buffer_load),    load);
    chk({tag, ".last"},     int'(output_buffer_last),    last);
    chk({tag, ".busy"},     int'(busy),                  bsy);
    @(posedge clk);
    #1;
  endtask

  task automatic permute(input string tag, input int n);
    for (int i = 0; i < n; i++) outs(tag, 0, 0, 0, 1, i * RSTEP, 0, 0, 1);
  endtask

  task automatic single_block(input string tag);
    control_regs_valid = 1'b1; out_len_blocks = 16'd1;
    outs({tag, ".hdr"}, 0, 0, 1, 0, 0, 0, 0, 0);
    control_regs_valid = 1'b0; input_buffer_ready_rd = 1'b1; last_block_in_buffer_rd = 1'b1;
    outs({tag, ".abs"}, 1, 1, 0, 0, 0, 0, 0, 1);
    input_buffer_ready_rd = 1'b0; last_block_in_buffer_rd = 1'b0; output_buffer_empty = 1'b1;
    permute({tag, ".perm"}, RCYC);
    outs({tag, ".load"}, 0, 0, 0, 0, 0, 1, 1, 1);
    outs({tag, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; control_regs_valid = 1'b1; out_len_blocks = 16'd4;
    input_buffer_ready_rd = 1'b1; last_block_in_buffer_rd = 1'b0; output_buffer_empty = 1'b1;
    @(posedge clk); #1;
    outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; control_regs_valid = 1'b0; input_buffer_ready_rd = 1'b0;
    outs("idle0", 0, 0, 0, 0, 0, 0, 0, 0);

    single_block("single");

    // Three input blocks, ready held high; only the third carries last.
    control_regs_valid = 1'b1; out_len_blocks = 16'd1;
    outs("three.hdr", 0, 0, 1, 0, 0, 0, 0, 0);
    control_regs_valid = 1'b0; input_buffer_ready_rd = 1'b1; last_block_in_buffer_rd = 1'b0;
    outs("three.abs0", 1, 1, 0, 0, 0, 0, 0, 1);
    permute("three.perm0", RCYC);
    outs("three.abs1", 1, 1, 0, 0, 0, 0, 0, 1);
    permute("three.perm1", RCYC);
    last_block_in_buffer_rd = 1'b1;
    outs("three.abs2", 1, 1, 0, 0, 0, 0, 0, 1);
    input_buffer_ready_rd = 1'b0; last_block_in_buffer_rd = 1'b0;
    permute("three.perm2", RCYC);
    outs("three.load", 0, 0, 0, 0, 0, 1, 1, 1);
    outs("three.idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Three output blocks with a 10-cycle output stall before the first.
    control_regs_valid = 1'b1; out_len_blocks = 16'd3;
    outs("sq3.hdr", 0, 0, 1, 0, 0, 0, 0, 0);
    control_regs_valid = 1'b0; input_buffer_ready_rd = 1'b1; last_block_in_buffer_rd = 1'b1;
    outs("sq3.abs", 1, 1, 0, 0, 0, 0, 0, 1);
    input_buffer_ready_rd = 1'b0; last_block_in_buffer_rd = 1'b0;
    permute("sq3.perm0", RCYC);
    output_buffer_empty = 1'b0;
    for (int i = 0; i < 10; i++) outs("sq3.stall", 0, 0, 0, 0, 0, 0, 0, 1);
    output_buffer_empty = 1'b1;
    outs("sq3.load0", 0, 0, 0, 0, 0, 1, 0, 1);
    permute("sq3.perm1", RCYC);
    outs("sq3.load1", 0, 0, 0, 0, 0, 1, 0, 1);
    permute("sq3.perm2", RCYC);
    outs("sq3.load2", 0, 0, 0, 0, 0, 1, 1, 1);
    outs("sq3.idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Zero length means one block; a header during PERMUTE must not relatch.
    control_regs_valid = 1'b1; out_len_blocks = 16'd0;
    outs("len0.hdr", 0, 0, 1, 0, 0, 0, 0, 0);
    control_regs_valid = 1'b0; input_buffer_ready_rd = 1'b1; last_block_in_buffer_rd = 1'b1;
    outs("len0.abs", 1, 1, 0, 0, 0, 0, 0, 1);
    input_buffer_ready_rd = 1'b0; last_block_in_buffer_rd = 1'b0;
    control_regs_valid = 1'b1; out_len_blocks = 16'd5;
    permute("len0.perm", RCYC);
    control_regs_valid = 1'b0;
    outs("len0.load", 0, 0, 0, 0, 0, 1, 1, 1);
    outs("len0.idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset pulsed in the middle of a permutation.
    control_regs_valid = 1'b1; out_len_blocks = 16'd2;
    outs("mid.hdr", 0, 0, 1, 0, 0, 0, 0, 0);
    control_regs_valid = 1'b0; input_buffer_ready_rd = 1'b1; last_block_in_buffer_rd = 1'b1;
    outs("mid.abs", 1, 1, 0, 0, 0, 0, 0, 1);
    last_block_in_buffer_rd = 1'b0;
    permute("mid.perm", RCYC / 2);
    rst = 1'b1;
    outs("mid.rstcyc", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    outs("mid.after", 0, 0, 0, 0, 0, 0, 0, 0);
    input_buffer_ready_rd = 1'b0;
    single_block("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
